puf_majority_voter: RTL

- Downstream consumer of the 128-bit PUF core.
- Drives the PUF `signal` enable, waits for the delay paths to settle, then samples `response` on several consecutive cycles.
- Resolves each bit by majority vote to produce one stable key word with a valid flag.
- Feeds key storage and compare logic; shields it from metastable or noisy PUF bits.

---
 rtl/puf_majority_voter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/puf_majority_voter.sv
// puf_majority_voter
//   Drives the PUF enable, waits SETTLE_CYCLES for the delay paths to settle,
//   captures the response on NUM_SAMPLES consecutive cycles and resolves each
//   bit by majority vote into a stable key word.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle key request (honoured only in IDLE or DONE)
//   response_in  PUF response bus (WIDTH)
//   puf_enable   PUF signal enable (high in SETTLE and SAMPLE)
//   busy         high in SETTLE, SAMPLE and RESOLVE
//   key_valid    high in DONE; key_out stable while high
//   key_out      majority-voted key (WIDTH)
//
// Optional feature (macro PUF_VOTER_UNSTABLE_MASK_EN)
//   unstable_mask  per-bit flag: the bit was not unanimous across samples
//   unstable_any   OR-reduction of unstable_mask
module puf_majority_voter #(
    parameter int WIDTH         = 128,
    parameter int NUM_SAMPLES   = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] response_in,
    output logic             puf_enable,
    output logic             busy,
    output logic             key_valid,
    output logic [WIDTH-1:0] key_out
`ifdef PUF_VOTER_UNSTABLE_MASK_EN
    ,
    output logic [WIDTH-1:0] unstable_mask,
    output logic             unstable_any
`endif
);

    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    generate
        if ((NUM_SAMPLES < 3) || (NUM_SAMPLES % 2 == 0)) begin : g_bad_samples
            $error("puf_majority_voter: NUM_SAMPLES must be odd and >= 3");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("puf_majority_voter: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        SAMPLE  = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [SW-1:0]           settle_cnt;
    logic [CW-1:0]           sample_cnt;
    logic [WIDTH-1:0][CW-1:0] ones_cnt;
    logic                    start_req;

    // A request is only honoured from IDLE or DONE; elsewhere it is dropped.
    assign start_req = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        puf_enable = 1'b0;
        busy       = 1'b0;
        key_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SETTLE;
            end
            SETTLE: begin
                puf_enable = 1'b1;
                busy       = 1'b1;
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                puf_enable = 1'b1;
                busy       = 1'b1;
                if (sample_cnt == CW'(NUM_SAMPLES - 1)) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                key_valid = 1'b1;
                if (start) state_nxt = SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle/sample counters and per-bit ones counters. Counters are cleared
    // when a new key is requested; the last increment of each phase leaves the
    // counter at its terminal value, which is harmless until the next clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (start_req) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else if (state == SAMPLE) begin
            sample_cnt <= sample_cnt + CW'(1);
            for (int i = 0; i < WIDTH; i++)
                ones_cnt[i] <= ones_cnt[i] + CW'(response_in[i]);
        end
    end

    // key_out is only written in RESOLVE, so it holds through DONE and the
    // following SETTLE/SAMPLE of a back-to-back request.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_out <= '0;
        end else if (state == RESOLVE) begin
            for (int i = 0; i < WIDTH; i++)
                key_out[i] <= (ones_cnt[i] > CW'(NUM_SAMPLES / 2));
        end
    end

`ifdef PUF_VOTER_UNSTABLE_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            unstable_mask <= '0;
        end else if (state == RESOLVE) begin
            for (int i = 0; i < WIDTH; i++)
                unstable_mask[i] <= (ones_cnt[i] != '0) &&
                                    (ones_cnt[i] != CW'(NUM_SAMPLES));
        end
    end

    assign unstable_any = |unstable_mask;
`endif

endmodule
